pmem_arbiter: RTL and testbench

Two-client arbiter between the pipelined I-cache and the D-cache on the miss side, sharing the single cacheline-wide physical-memory port (cacheline adaptor). It grants one outstanding 256-bit line transaction at a time. On a tie it uses round-robin priority. It latches the winner's address and write data so the memory port stays stable for the whole transaction, and it routes the response back to the granted client only.

---
 rtl/pmem_arbiter_pkg.sv | 16 +
 rtl/pmem_arbiter.sv | 111 +++++++++++
 tb/tb_pmem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the miss-side memory arbiter: line/address widths and
// the arbiter state encoding.
package pmem_arbiter_pkg;

    // Cacheline and byte-address widths of the physical-memory port.
    localparam int PMEM_LINE_W = 256;
    localparam int PMEM_ADDR_W = 32;

    // Arbiter states: grant evaluation, then one transaction per client.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Two-client arbiter (I-cache, D-cache) for the single cacheline-wide
// physical-memory port. One line transaction is outstanding at a time; ties
// are broken round-robin, and the winner's address/write line are latched so
// the memory side stays stable until mem_resp.
//
// Handshake: a client raises its request (read or write) and holds it, with
// its address and write line, until it sees its one-cycle x_pmem_resp; it must
// drop the request on that edge. The memory side holds mem_read/mem_write
// until its one-cycle mem_resp; mem_rdata is valid in that same cycle.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int LINE_W = PMEM_LINE_W,
    parameter int ADDR_W = PMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_d;   // 1: D-cache was served last, so I wins the next tie
    logic       i_req;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Next-state and grant decision; grants only happen from IDLE.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_d)) begin
                    state_next = SERVE_I;
                    grant_i    = 1'b1;
                end else if (d_req) begin
                    state_next = SERVE_D;
                    grant_d    = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, round-robin history and the latched memory-side request.
    // A simultaneous D read+write is treated as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_d      <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                last_d      <= 1'b0;
                mem_address <= i_pmem_address;
                mem_read    <= 1'b1;
                mem_write   <= 1'b0;
            end else if (grant_d) begin
                last_d      <= 1'b1;
                mem_address <= d_pmem_address;
                mem_wdata   <= d_pmem_wdata;
                mem_read    <= d_pmem_read & ~d_pmem_write;
                mem_write   <= d_pmem_write;
            end else if ((state != IDLE) && mem_resp) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

    // Response routing: only the granted client sees mem_resp; a stray
    // mem_resp in IDLE reaches nobody. Read data is forwarded unconditionally.
    assign i_pmem_resp  = (state == SERVE_I) && mem_resp;
    assign d_pmem_resp  = (state == SERVE_D) && mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the arbitration rules.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    localparam int LW = PMEM_LINE_W;
    localparam int AW = PMEM_ADDR_W;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    // A D-cache read and write together is illegal client behaviour.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (!(d_pmem_read && d_pmem_write))
                else $error("FAIL d_read_write_both asserted together");
        end
    end

    // ---------------- model / scoreboard state ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
    } req_t;

    req_t          iq[$];        // pending I-cache requests, in issue order
    req_t          dq[$];        // pending D-cache requests, in issue order
    logic [AW-1:0] exp_q[$];     // expected address of the in-flight memory transaction
    bit            m_last_d;     // model: client served last was D
    int            checks = 0;
    int            passed = 0;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic req_t mk_req(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd);
        req_t r;
        r.addr  = a;
        r.wr    = w;
        r.wdata = wd;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_resp       = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last_d = 1'b1;
    endtask

    // Runs the client queues to completion with the bench acting as memory
    // (latency lat_min..lat_max after strobe). Called at posedge+1 with the
    // DUT in IDLE. The model decides, transaction by transaction, which
    // client must be granted and when, then checks every cycle.
    task automatic run_engine(input string tag, input int lat_min, input int lat_max,
                              input int gap_max, input int budget);
        int n_i, n_d, got_i, got_d, i_wait, d_wait, s_cyc, k, who;
        bit i_act, d_act, busy, resp_now, prev_idle, prev_i, prev_d, done;
        req_t i_cur, d_cur, cur;
        logic [LW-1:0] line;
        logic exp_ir, exp_dr;
        n_i = iq.size(); n_d = dq.size();
        got_i = 0; got_d = 0; i_wait = 0; d_wait = 0; s_cyc = 0; k = 1; who = 0;
        i_act = 0; d_act = 0; busy = 0; prev_idle = 1; prev_i = 0; prev_d = 0; done = 0;
        i_cur = mk_req('0, 1'b0, '0); d_cur = i_cur; cur = i_cur;
        exp_q.delete();
        for (int c = 0; c < budget && !done; c++) begin
            resp_now = busy && (c == s_cyc + k);
            if (!i_act && iq.size() > 0) begin
                if (i_wait > 0) i_wait--; else begin i_cur = iq.pop_front(); i_act = 1; end
            end
            if (!d_act && dq.size() > 0) begin
                if (d_wait > 0) d_wait--; else begin d_cur = dq.pop_front(); d_act = 1; end
            end
            // The client being served is free to change its address/data inputs.
            i_pmem_read    = i_act;
            i_pmem_address = (i_act && !(busy && who == 0)) ? i_cur.addr : $urandom;
            d_pmem_read    = d_act && !d_cur.wr;
            d_pmem_write   = d_act && d_cur.wr;
            if (d_act && !(busy && who == 1)) begin
                d_pmem_address = d_cur.addr;
                d_pmem_wdata   = d_cur.wdata;
            end else begin
                d_pmem_address = $urandom;
                d_pmem_wdata   = rand_line();
            end
            line      = rand_line();
            mem_rdata = line;
            mem_resp  = resp_now;

            @(negedge clk);
            // A request seen in an IDLE cycle is granted at that cycle's closing edge.
            if (!busy && prev_idle && (prev_i || prev_d)) begin
                who      = (prev_i && prev_d) ? (m_last_d ? 0 : 1) : (prev_i ? 0 : 1);
                m_last_d = (who == 1);
                cur      = (who == 1) ? d_cur : i_cur;
                exp_q.push_back(cur.addr);
                busy  = 1;
                s_cyc = c;
                k     = $urandom_range(lat_min, lat_max);
            end
            checks++;
            if (mem_read !== (busy && !cur.wr))
                $display("FAIL %s mem_read cyc %0d got %0b exp %0b", tag, c, mem_read, busy && !cur.wr);
            else passed++;
            checks++;
            if (mem_write !== (busy && cur.wr))
                $display("FAIL %s mem_write cyc %0d got %0b exp %0b", tag, c, mem_write, busy && cur.wr);
            else passed++;
            if (busy) begin
                checks++;
                if (mem_address !== exp_q[0])
                    $display("FAIL %s mem_address cyc %0d got %h exp %h", tag, c, mem_address, exp_q[0]);
                else passed++;
                if (cur.wr) begin
                    checks++;
                    if (mem_wdata !== cur.wdata)
                        $display("FAIL %s mem_wdata cyc %0d got %h exp %h", tag, c, mem_wdata, cur.wdata);
                    else passed++;
                end
            end
            exp_ir = resp_now && (who == 0);
            exp_dr = resp_now && (who == 1);
            checks++;
            if (i_pmem_resp !== exp_ir)
                $display("FAIL %s i_pmem_resp cyc %0d got %0b exp %0b", tag, c, i_pmem_resp, exp_ir);
            else passed++;
            checks++;
            if (d_pmem_resp !== exp_dr)
                $display("FAIL %s d_pmem_resp cyc %0d got %0b exp %0b", tag, c, d_pmem_resp, exp_dr);
            else passed++;
            checks++;
            if (i_pmem_rdata !== line)
                $display("FAIL %s i_pmem_rdata cyc %0d got %h exp %h", tag, c, i_pmem_rdata, line);
            else passed++;
            checks++;
            if (d_pmem_rdata !== line)
                $display("FAIL %s d_pmem_rdata cyc %0d got %h exp %h", tag, c, d_pmem_rdata, line);
            else passed++;

            prev_idle = !busy;
            prev_i    = i_pmem_read;
            prev_d    = d_pmem_read || d_pmem_write;
            if (resp_now) begin
                busy = 0;
                void'(exp_q.pop_front());
                if (who == 0) begin i_act = 0; got_i++; i_wait = $urandom_range(0, gap_max); end
                else          begin d_act = 0; got_d++; d_wait = $urandom_range(0, gap_max); end
            end
            done = !busy && !i_act && !d_act && (iq.size() == 0) && (dq.size() == 0);
            @(posedge clk); #1;
        end
        // Clients drop their requests on the final response edge.
        idle_inputs();
        checks++;
        if (!done) $display("FAIL %s timeout after %0d cycles", tag, budget);
        else passed++;
        checks++;
        if (got_i != n_i) $display("FAIL %s i_resp_count got %0d exp %0d", tag, got_i, n_i);
        else passed++;
        checks++;
        if (got_d != n_d) $display("FAIL %s d_resp_count got %0d exp %0d", tag, got_d, n_d);
        else passed++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst       = 1'b1;
        mem_resp  = 1'b1;   // stray response held through reset and into IDLE
        mem_rdata = rand_line();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) $display("FAIL reset mem_read got %0b exp 0", mem_read); else passed++;
        checks++; if (mem_write !== 1'b0) $display("FAIL reset mem_write got %0b exp 0", mem_write); else passed++;
        checks++; if (mem_address !== '0) $display("FAIL reset mem_address got %h exp 0", mem_address); else passed++;
        checks++; if (mem_wdata !== '0) $display("FAIL reset mem_wdata got %h exp 0", mem_wdata); else passed++;
        checks++; if (i_pmem_resp !== 1'b0) $display("FAIL reset i_pmem_resp got %0b exp 0", i_pmem_resp); else passed++;
        checks++; if (d_pmem_resp !== 1'b0) $display("FAIL reset d_pmem_resp got %0b exp 0", d_pmem_resp); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (i_pmem_resp !== 1'b0) $display("FAIL stray i_pmem_resp got %0b exp 0", i_pmem_resp); else passed++;
        checks++; if (d_pmem_resp !== 1'b0) $display("FAIL stray d_pmem_resp got %0b exp 0", d_pmem_resp); else passed++;
        checks++; if (mem_read !== 1'b0) $display("FAIL stray mem_read got %0b exp 0", mem_read); else passed++;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        m_last_d = 1'b1;
    endtask

    task automatic test_i_read();
        iq.push_back(mk_req(32'h0000_0040, 1'b0, '0));
        run_engine("i_read", 3, 3, 0, 50);
    endtask

    task automatic test_d_write();
        dq.push_back(mk_req(32'h0000_1000, 1'b1, {32{8'h55}}));
        run_engine("d_write", 4, 4, 0, 50);
    endtask

    task automatic test_tie();
        apply_reset();
        iq.push_back(mk_req(32'h0000_0080, 1'b0, '0));
        dq.push_back(mk_req(32'h0000_2000, 1'b0, '0));
        run_engine("tie_first", 2, 2, 0, 50);
        iq.push_back(mk_req(32'h0000_0100, 1'b0, '0));
        run_engine("tie_lone_i", 2, 2, 0, 50);
        iq.push_back(mk_req(32'h0000_0180, 1'b0, '0));
        dq.push_back(mk_req(32'h0000_2040, 1'b1, rand_line()));
        run_engine("tie_second", 1, 3, 0, 60);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) iq.push_back(mk_req(AW'(32'h0000_4000 + i * 32), 1'b0, '0));
        run_engine("back_to_back", 1, 3, 0, 200);
    endtask

    task automatic test_reset_mid();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0300;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) $display("FAIL rst_mid granted mem_read got %0b exp 1", mem_read); else passed++;
        checks++; if (mem_address !== 32'h0000_0300) $display("FAIL rst_mid mem_address got %h exp 00000300", mem_address); else passed++;
        @(posedge clk); #1;
        rst         = 1'b1;
        i_pmem_read = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_resp  = 1'b1;   // late response for the abandoned transaction
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) $display("FAIL rst_mid mem_read got %0b exp 0", mem_read); else passed++;
        checks++; if (mem_address !== '0) $display("FAIL rst_mid mem_address_clr got %h exp 0", mem_address); else passed++;
        checks++; if (i_pmem_resp !== 1'b0) $display("FAIL rst_mid late i_pmem_resp got %0b exp 0", i_pmem_resp); else passed++;
        checks++; if (d_pmem_resp !== 1'b0) $display("FAIL rst_mid late d_pmem_resp got %0b exp 0", d_pmem_resp); else passed++;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) $display("FAIL rst_mid after mem_read got %0b exp 0", mem_read); else passed++;
        @(posedge clk); #1;
        m_last_d = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            iq.push_back(mk_req($urandom, 1'b0, '0));
            dq.push_back(mk_req($urandom, 1'($urandom_range(0, 1)), rand_line()));
        end
        run_engine("random", 1, 6, 3, 3000);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        m_last_d = 1'b1;
        idle_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
